qspi_target: RTL and testbench

QSPI_TARGET -- requirements
Module: qspi_target

---
 rtl/qspi_pkg.sv | 21 ++
 rtl/qspi_sync.sv | 53 +++++
 rtl/qspi_target.sv | 188 ++++++++++++++++++
 tb/tb_qspi_target.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI target and its initiator models:
// FSM encoding, default command codes and phase nibble counts.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } qspi_state_e;

    localparam logic [7:0] CMD_READ_DEF  = 8'hEB;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h38;

    localparam int CMD_NIBBLES  = 2;
    localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_sync.sv
// Brings sclk, cs_n and sio_in into the clk domain through two flops and
// derives single-cycle sclk rise/fall and cs_n fall strobes.
module qspi_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic [3:0] sio_i,
    output logic       sclk_rise_o,
    output logic       sclk_fall_o,
    output logic       cs_n_o,
    output logic       cs_fall_o,
    output logic [3:0] sio_o
);

    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic [3:0] sio_meta_q, sio_sync_q;
    logic [1:0] flush_q;

    // cs_prev_q only reports high once the reset values have left the
    // synchronizer, so a cs_n held low across reset is not seen as a fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b0;
            sio_meta_q  <= 4'h0;
            sio_sync_q  <= 4'h0;
            flush_q     <= 2'b00;
        end else begin
            sclk_meta_q <= sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs_n_i;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= flush_q[1] & cs_sync_q;
            sio_meta_q  <= sio_i;
            sio_sync_q  <= sio_meta_q;
            flush_q     <= {flush_q[0], 1'b1};
        end
    end

    assign sclk_rise_o = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_sync_q & sclk_prev_q;
    assign cs_n_o      = cs_sync_q;
    assign cs_fall_o   = ~cs_sync_q & cs_prev_q;
    assign sio_o       = sio_sync_q;

endmodule

// File: rtl/qspi_target.sv
// Quad-SPI memory target: command/address/dummy/data phases over four data
// lines, backed by a byte memory that also has a registered host port.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int         DEPTH     = 256,
    parameter int         DUMMY     = 6,
    parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic [3:0]               sio_in,
    output logic [3:0]               sio_out,
    output logic [3:0]               sio_oe,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [7:0]               host_wdata,
    output logic [7:0]               host_rdata,
    output logic                     busy
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [7:0] CMD_LAST   = 8'(CMD_NIBBLES - 1);
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);

    logic       sclk_rise, sclk_fall, cs_n_s, cs_fall;
    logic [3:0] sio_s;

    qspi_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .sclk_i     (sclk),
        .cs_n_i     (cs_n),
        .sio_i      (sio_in),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .cs_n_o     (cs_n_s),
        .cs_fall_o  (cs_fall),
        .sio_o      (sio_s)
    );

    qspi_state_e   state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [19:0]   shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          is_read_q, is_read_d;
    logic          half_q, half_d;
    logic [3:0]    wnib_q, wnib_d;
    logic [3:0]    out_q, out_d;
    logic          oe_q, oe_d;
    logic [7:0]    host_rdata_q;
    logic [7:0]    mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [7:0]    cmd_byte, rd_byte;
    logic [23:0]   addr_full;
    logic          unused_addr_hi;

    assign cmd_byte       = {shift_q[3:0], sio_s};
    assign addr_full      = {shift_q, sio_s};
    assign rd_byte        = mem_q[ptr_q];
    assign unused_addr_hi = ^addr_full[23:AW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_CMD;
            ST_CMD:   if (sclk_rise && cnt_q == CMD_LAST)
                          state_d = (cmd_byte == CMD_READ || cmd_byte == CMD_WRITE)
                                    ? ST_ADDR : ST_IGNORE;
            ST_ADDR:  if (sclk_rise && cnt_q == ADDR_LAST)
                          state_d = !is_read_q ? ST_WDATA
                                  : (DUMMY == 0) ? ST_RDATA : ST_DUMMY;
            ST_DUMMY: if (sclk_rise && cnt_q == DUMMY_LAST) state_d = ST_RDATA;
            default:  state_d = state_q;
        endcase
        if (state_q != ST_IDLE && cs_n_s) state_d = ST_IDLE;
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        is_read_d = is_read_q;
        half_d    = half_q;
        wnib_d    = wnib_q;
        out_d     = out_q;
        oe_d      = oe_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = {wnib_q, sio_s};
        case (state_q)
            ST_IDLE: begin
                cnt_d  = 8'd0;
                half_d = 1'b0;
                oe_d   = 1'b0;
                if (host_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = host_addr;
                    mem_wdata = host_wdata;
                end
            end
            ST_CMD: if (sclk_rise) begin
                shift_d = {shift_q[15:0], sio_s};
                cnt_d   = (cnt_q == CMD_LAST) ? 8'd0 : cnt_q + 8'd1;
                if (cnt_q == CMD_LAST) is_read_d = (cmd_byte == CMD_READ);
            end
            ST_ADDR: if (sclk_rise) begin
                shift_d = {shift_q[15:0], sio_s};
                cnt_d   = (cnt_q == ADDR_LAST) ? 8'd0 : cnt_q + 8'd1;
                if (cnt_q == ADDR_LAST) ptr_d = addr_full[AW-1:0];
            end
            ST_DUMMY: if (sclk_rise) begin
                cnt_d = (cnt_q == DUMMY_LAST) ? 8'd0 : cnt_q + 8'd1;
            end
            ST_RDATA: if (sclk_fall) begin
                oe_d   = 1'b1;
                half_d = ~half_q;
                out_d  = half_q ? rd_byte[3:0] : rd_byte[7:4];
                if (half_q) ptr_d = ptr_q + 1'b1;
            end
            ST_WDATA: if (sclk_rise) begin
                half_d = ~half_q;
                if (!half_q) begin
                    wnib_d = sio_s;
                end else begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Deselect discards any half-collected nibble or byte.
        if (state_q != ST_IDLE && cs_n_s) begin
            cnt_d  = 8'd0;
            half_d = 1'b0;
            oe_d   = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= 8'd0;
            shift_q      <= 20'd0;
            ptr_q        <= '0;
            is_read_q    <= 1'b0;
            half_q       <= 1'b0;
            wnib_q       <= 4'h0;
            out_q        <= 4'h0;
            oe_q         <= 1'b0;
            host_rdata_q <= 8'h00;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            is_read_q    <= is_read_d;
            half_q       <= half_d;
            wnib_q       <= wnib_d;
            out_q        <= out_d;
            oe_q         <= oe_d;
            host_rdata_q <= mem_q[host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        sio_oe     = {4{oe_q & (state_q == ST_RDATA) & ~cs_n_s}};
        sio_out    = out_q;
        host_rdata = host_rdata_q;
    end

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: an initiator model drives sclk at 1/16 of
// clk, and each scenario task compares observed values with hand-derived ones.
module tb_qspi_target;
  import qspi_pkg::*;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out, sio_oe;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       busy;

  int n_checks = 0;
  int n_pass = 0;

  logic [3:0] obs_out, obs_oe_rise, obs_oe_fall, oe_acc;

  qspi_target #(.DEPTH(256), .DUMMY(6)) dut (
    .clk(clk), .reset(rst_n), .sclk(sclk), .cs_n(cs_n), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic qspi_clock(input logic [3:0] nib);
    sio_in = nib;
    repeat (HALF) @(negedge clk);
    obs_out = sio_out;
    obs_oe_rise = sio_oe;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    obs_oe_fall = sio_oe;
    sclk = 1'b0;
    oe_acc = oe_acc | obs_oe_rise | obs_oe_fall;
  endtask

  task automatic send_byte(input logic [7:0] b);
    qspi_clock(b[7:4]);
    qspi_clock(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) qspi_clock(a[i*4 +: 4]);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic read_start(input logic [23:0] a);
    oe_acc = 4'h0;
    cs_begin();
    send_byte(CMD_READ_DEF);
    send_addr(a);
    for (int i = 0; i < 6; i++) qspi_clock(4'h0);
  endtask

  task automatic read_data(input int n, output logic [31:0] nibs, output logic [3:0] oe_all);
    nibs = 32'h0;
    oe_all = 4'hF;
    for (int i = 0; i < n; i++) begin
      qspi_clock(4'h0);
      nibs = {nibs[27:0], obs_out};
      oe_all = oe_all & obs_oe_rise;
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (sio_out !== 4'h0) $display("FAIL rst_sio_out got %h exp 0", sio_out); else n_pass++;
    n_checks++; if (sio_oe !== 4'h0) $display("FAIL rst_sio_oe got %h exp 0", sio_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (host_rdata !== 8'h00) $display("FAIL rst_host_rdata got %h exp 00", host_rdata); else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_host_port();
    logic [7:0] d;
    host_write(8'h10, 8'h11);
    host_write(8'h11, 8'h22);
    host_write(8'h12, 8'h33);
    host_write(8'h13, 8'h44);
    host_write(8'h20, 8'h00);
    host_write(8'h21, 8'h77);
    host_write(8'h30, 8'h00);
    host_read(8'h10, d);
    n_checks++; if (d !== 8'h11) $display("FAIL host_rd_10 got %h exp 11", d); else n_pass++;
    host_read(8'h13, d);
    n_checks++; if (d !== 8'h44) $display("FAIL host_rd_13 got %h exp 44", d); else n_pass++;
  endtask

  task automatic test_quad_read();
    logic [31:0] nibs;
    logic [3:0]  oe_all, oe_early;
    read_start(24'h000010);
    oe_early = oe_acc;
    read_data(8, nibs, oe_all);
    n_checks++; if (oe_early !== 4'h0) $display("FAIL read_oe_early got %h exp 0", oe_early); else n_pass++;
    n_checks++; if (nibs !== 32'h11223344) $display("FAIL read_nibbles got %h exp 11223344", nibs); else n_pass++;
    n_checks++; if (oe_all !== 4'hF) $display("FAIL read_oe_data got %h exp F", oe_all); else n_pass++;
    cs_end();
    n_checks++; if (sio_oe !== 4'h0) $display("FAIL read_oe_after_cs got %h exp 0", sio_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL read_busy_after_cs got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_write_wrap();
    logic [7:0] d;
    oe_acc = 4'h0;
    cs_begin();
    send_byte(CMD_WRITE_DEF);
    send_addr(24'h0000FF);
    send_byte(8'hAA);
    send_byte(8'hBB);
    cs_end();
    n_checks++; if (oe_acc !== 4'h0) $display("FAIL write_oe got %h exp 0", oe_acc); else n_pass++;
    host_read(8'hFF, d);
    n_checks++; if (d !== 8'hAA) $display("FAIL write_mem_ff got %h exp AA", d); else n_pass++;
    host_read(8'h00, d);
    n_checks++; if (d !== 8'hBB) $display("FAIL write_wrap_mem_00 got %h exp BB", d); else n_pass++;
  endtask

  task automatic test_partial_write();
    logic [7:0] d;
    cs_begin();
    send_byte(CMD_WRITE_DEF);
    send_addr(24'h000020);
    qspi_clock(4'hA);
    qspi_clock(4'hB);
    qspi_clock(4'hC);
    n_checks++; if (busy !== 1'b1) $display("FAIL partial_busy_before got %b exp 1", busy); else n_pass++;
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL partial_busy_3clk got %b exp 0", busy); else n_pass++;
    repeat (HALF) @(negedge clk);
    host_read(8'h20, d);
    n_checks++; if (d !== 8'hAB) $display("FAIL partial_mem_20 got %h exp AB", d); else n_pass++;
    host_read(8'h21, d);
    n_checks++; if (d !== 8'h77) $display("FAIL partial_mem_21 got %h exp 77", d); else n_pass++;
  endtask

  task automatic test_ignore();
    logic [7:0]  d;
    logic [31:0] nibs;
    logic [3:0]  oe_all;
    cs_begin();
    send_byte(8'h05);
    oe_acc = 4'h0;
    for (int i = 0; i < 10; i++) qspi_clock(4'hF);
    n_checks++; if (oe_acc !== 4'h0) $display("FAIL ignore_oe got %h exp 0", oe_acc); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL ignore_busy got %b exp 1", busy); else n_pass++;
    cs_end();
    host_read(8'h10, d);
    n_checks++; if (d !== 8'h11) $display("FAIL ignore_mem_10 got %h exp 11", d); else n_pass++;
    read_start(24'h000012);
    read_data(4, nibs, oe_all);
    cs_end();
    n_checks++; if (nibs[15:0] !== 16'h3344) $display("FAIL ignore_next_read got %h exp 3344", nibs[15:0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] nibs;
    logic [3:0]  oe_all;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    read_start(24'h000011);
    read_data(2, nibs, oe_all);
    cs_end();
    n_checks++; if (nibs[7:0] !== 8'h22) $display("FAIL b2b_read got %h exp 22", nibs[7:0]); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [7:0]  d;
    logic [31:0] nibs;
    logic [3:0]  oe_all;
    read_start(24'h000010);
    read_data(2, nibs, oe_all);
    n_checks++; if (sio_oe !== 4'hF) $display("FAIL midrst_oe_before got %h exp F", sio_oe); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (sio_oe !== 4'h0) $display("FAIL midrst_oe_async got %h exp 0", sio_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qspi_clock(4'hE);
    qspi_clock(4'hB);
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_no_fresh_fall got %b exp 0", busy); else n_pass++;
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    read_start(24'h0000FF);
    read_data(2, nibs, oe_all);
    cs_end();
    n_checks++; if (nibs[7:0] !== 8'hAA) $display("FAIL midrst_read_ff got %h exp AA", nibs[7:0]); else n_pass++;
    host_read(8'h13, d);
    n_checks++; if (d !== 8'h44) $display("FAIL midrst_mem_kept got %h exp 44", d); else n_pass++;
  endtask

  task automatic test_host_busy();
    logic [7:0] d;
    cs_begin();
    n_checks++; if (busy !== 1'b1) $display("FAIL hostbusy_busy got %b exp 1", busy); else n_pass++;
    host_write(8'h30, 8'h5A);
    cs_end();
    host_read(8'h30, d);
    n_checks++; if (d !== 8'h00) $display("FAIL hostbusy_blocked got %h exp 00", d); else n_pass++;
    host_write(8'h30, 8'h5A);
    host_read(8'h30, d);
    n_checks++; if (d !== 8'h5A) $display("FAIL hostbusy_idle_write got %h exp 5A", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_host_port();
    test_quad_read();
    test_write_wrap();
    test_partial_write();
    test_ignore();
    test_back_to_back();
    test_reset_mid_read();
    test_host_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
